// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults, derived totals and the state/phase encodings
// used by the VGA timing controller and its per-axis counter.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

endpackage

// File: rtl/vga_axis_ctrl.sv
// One timing axis: wrapping counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Count and phase update on the edge where i_step is high; i_clr wins over i_step.
module vga_axis_ctrl
    import vga_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_step,
    input  logic             i_wrap_en,
    output logic [CNT_W-1:0] o_count,
    output phase_t           o_phase_nxt,
    output logic             o_wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CNT_W-1:0] C_FRONT = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] C_SYNC  = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] C_BACK  = CNT_W'(ACTIVE + FP + SYNC);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    phase_t           r_phase;
    phase_t           w_phase_nxt;
    logic             w_at_last;

    assign w_at_last = (r_count == C_LAST);

    always_comb begin
        w_count_nxt = r_count;
        if (i_clr) begin
            w_count_nxt = '0;
        end else if (i_step) begin
            if (!w_at_last) begin
                w_count_nxt = r_count + C_ONE;
            end else if (i_wrap_en) begin
                w_count_nxt = '0;
            end
        end
    end

    // Phase follows the count it will sit beside, so both flops always agree.
    always_comb begin
        w_phase_nxt = r_phase;
        if (i_clr) begin
            w_phase_nxt = PH_ACTIVE;
        end else if (i_step) begin
            case (r_phase)
                PH_ACTIVE: if (w_count_nxt == C_FRONT) w_phase_nxt = PH_FRONT;
                PH_FRONT:  if (w_count_nxt == C_SYNC)  w_phase_nxt = PH_SYNC;
                PH_SYNC:   if (w_count_nxt == C_BACK)  w_phase_nxt = PH_BACK;
                PH_BACK:   if (w_count_nxt == '0)      w_phase_nxt = PH_ACTIVE;
                default:   w_phase_nxt = PH_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        r_count <= w_count_nxt;
        r_phase <= w_phase_nxt;
    end

    assign o_count     = r_count;
    assign o_phase_nxt = w_phase_nxt;
    assign o_wrap      = w_at_last;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA sync/timing generator: IDLE/RUN control over horizontal and vertical axis counters.
// Every output is a flop updated on the same edge as hc/vc; pix_en low freezes RUN state.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pix_en,
    input  logic             enable,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             line_start,
    output logic             frame_start
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_start;
    logic             w_advance;
    logic             w_axis_clr;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_v_step;
    phase_t           w_h_phase_nxt;
    phase_t           w_v_phase_nxt;
    logic [CNT_W-1:0] w_hc;
    logic [CNT_W-1:0] w_vc;

    logic r_hsync;
    logic r_vsync;
    logic r_video_on;
    logic r_line_start;
    logic r_frame_start;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dropping enable beats a coincident pixel tick.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_advance   = 1'b0;
        if (clr || !enable) begin
            w_state_nxt = ST_IDLE;
        end else if (r_state == ST_IDLE) begin
            if (pix_en) begin
                w_state_nxt = ST_RUN;
                w_start     = 1'b1;
            end
        end else begin
            w_advance = pix_en;
        end
    end

    assign w_axis_clr = (w_state_nxt == ST_IDLE) || w_start;
    assign w_v_step   = w_advance && w_h_wrap;

    vga_axis_ctrl #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .i_clk       (clk),
        .i_clr       (w_axis_clr),
        .i_step      (w_advance),
        .i_wrap_en   (1'b1),
        .o_count     (w_hc),
        .o_phase_nxt (w_h_phase_nxt),
        .o_wrap      (w_h_wrap)
    );

    vga_axis_ctrl #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .i_clk       (clk),
        .i_clr       (w_axis_clr),
        .i_step      (w_v_step),
        .i_wrap_en   (1'b1),
        .o_count     (w_vc),
        .o_phase_nxt (w_v_phase_nxt),
        .o_wrap      (w_v_wrap)
    );

    // Decoded outputs are registered from next-state values to line up with hc/vc.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= (w_h_phase_nxt != PH_SYNC);
            r_vsync       <= (w_v_phase_nxt != PH_SYNC);
            r_video_on    <= (w_state_nxt == ST_RUN) &&
                             (w_h_phase_nxt == PH_ACTIVE) &&
                             (w_v_phase_nxt == PH_ACTIVE);
            r_line_start  <= w_start || w_v_step;
            r_frame_start <= w_start || (w_v_step && w_v_wrap);
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign hc          = w_hc;
    assign vc          = w_vc;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed checks of vga_timing_ctrl: full-size timing for line-level behaviour and a
// shrunken-timing instance (16x11 total) for frame-level behaviour within a short run.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr;
    logic       pix_en;
    logic       enable;

    logic       hsync, vsync, video_on, line_start, frame_start;
    logic [9:0] hc, vc;

    logic       s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
    logic [9:0] s_hc, s_vc;

    int n_total = 0;
    int n_bad   = 0;

    vga_timing_ctrl u_dut (
        .clk         (clk),
        .clr         (clr),
        .pix_en      (pix_en),
        .enable      (enable),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .hc          (hc),
        .vc          (vc),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    // Small timing: H 8/2/3/3 (sync at hc 10..12), V 6/1/2/2 (sync at vc 7..8).
    vga_timing_ctrl #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2)
    ) u_small (
        .clk         (clk),
        .clr         (clr),
        .pix_en      (pix_en),
        .enable      (enable),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .video_on    (s_video_on),
        .hc          (s_hc),
        .vc          (s_vc),
        .line_start  (s_line_start),
        .frame_start (s_frame_start)
    );

    task automatic step(input logic pe);
        pix_en = pe;
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        clr    = 1'b1;
        enable = 1'b1;
        step(1'b0);
        clr    = 1'b0;
        step(1'b1);
    endtask

    task automatic test_reset();
        clr    = 1'b1;
        enable = 1'b1;
        step(1'b1);
        step(1'b1);
        n_total++;
        if ({hc, vc} !== 20'd0) begin
            n_bad++; $display("FAIL reset_count hc=%0d vc=%0d want 0 0", hc, vc);
        end
        n_total++;
        if ({hsync, vsync, video_on, line_start, frame_start} !== 5'b11000) begin
            n_bad++; $display("FAIL reset_flags got=%b want=11000",
                              {hsync, vsync, video_on, line_start, frame_start});
        end
        n_total++;
        if ({s_hc, s_vc, s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start} !== {20'd0, 5'b11000}) begin
            n_bad++; $display("FAIL reset_small hc=%0d vc=%0d flags=%b", s_hc, s_vc,
                              {s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start});
        end
    endtask

    task automatic test_hline();
        int hc_err = 0, hs_low = 0, hs_first = -1, vid = 0, ls_cnt = 0, ls_clk = -1, clk_n;
        clr = 1'b1; step(1'b0); clr = 1'b0; enable = 1'b1;
        step(1'b0);
        n_total++;
        if ({video_on, line_start, frame_start} !== 3'b000) begin
            n_bad++; $display("FAIL idle_wait flags=%b want=000", {video_on, line_start, frame_start});
        end
        step(1'b1);
        n_total++;
        if ({hc, vc} !== 20'd0 || {line_start, frame_start, video_on, hsync, vsync} !== 5'b11111) begin
            n_bad++; $display("FAIL start_pulse hc=%0d vc=%0d flags=%b want 0 0 11111", hc, vc,
                              {line_start, frame_start, video_on, hsync, vsync});
        end
        vid = video_on ? 1 : 0;
        step(1'b0);
        clk_n = 1;
        n_total++;
        if ({line_start, frame_start} !== 2'b00 || hc !== 10'd0) begin
            n_bad++; $display("FAIL pulse_width ls=%b fs=%b hc=%0d want 0 0 0", line_start, frame_start, hc);
        end
        for (int k = 1; k <= 800; k++) begin
            step(1'b1);
            clk_n++;
            if (line_start) begin ls_cnt++; ls_clk = clk_n; end
            if (hc !== 10'(k % 800)) hc_err++;
            if (k < 800) begin
                if (!hsync) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = int'(hc);
                end
                if (video_on) vid++;
            end
            if (k == 640) begin
                n_total++;
                if (video_on !== 1'b0) begin
                    n_bad++; $display("FAIL video_hc640 got=%b want=0", video_on);
                end
            end
            if (k < 800) begin
                step(1'b0);
                clk_n++;
                if (line_start || frame_start) ls_cnt++;
            end
        end
        n_total++;
        if (hc_err != 0) begin n_bad++; $display("FAIL hc_sequence errors=%0d want=0", hc_err); end
        n_total++;
        if (hs_first != 656) begin n_bad++; $display("FAIL hsync_start hc=%0d want=656", hs_first); end
        n_total++;
        if (hs_low != 96) begin n_bad++; $display("FAIL hsync_width ticks=%0d want=96", hs_low); end
        n_total++;
        if (vid != 640) begin n_bad++; $display("FAIL line_video ticks=%0d want=640", vid); end
        n_total++;
        if (ls_cnt != 1 || ls_clk != 1600) begin
            n_bad++; $display("FAIL line_period pulses=%0d clk=%0d want 1 1600", ls_cnt, ls_clk);
        end
        n_total++;
        if ({hc, vc} !== {10'd0, 10'd1} || frame_start !== 1'b0 || hsync !== 1'b1) begin
            n_bad++; $display("FAIL h_wrap hc=%0d vc=%0d fs=%b hs=%b want 0 1 0 1", hc, vc, frame_start, hsync);
        end
    endtask

    task automatic test_frame();
        int ls = 0, fs_clk = -1, vs_low = 0, vs_first = -1, vid = 0, p_err = 0;
        restart();
        vid = s_video_on ? 1 : 0;
        for (int k = 1; k <= 176; k++) begin
            step(1'b0);
            if (s_line_start || s_frame_start) p_err++;
            step(1'b1);
            if (s_line_start) ls++;
            if (s_frame_start) fs_clk = 2 * k;
            if (k < 176) begin
                if (!s_vsync) begin
                    vs_low++;
                    if (vs_first < 0) vs_first = int'(s_vc) * 100 + int'(s_hc);
                end
                if (s_video_on) vid++;
            end
            if (s_hc == 10'd8 && s_vc == 10'd0) begin
                n_total++;
                if (s_video_on !== 1'b0) begin n_bad++; $display("FAIL video_hc_edge got=%b want=0", s_video_on); end
            end
            if (s_hc == 10'd0 && s_vc == 10'd6) begin
                n_total++;
                if (s_video_on !== 1'b0) begin n_bad++; $display("FAIL video_vc_edge got=%b want=0", s_video_on); end
            end
        end
        n_total++;
        if (ls != 11) begin n_bad++; $display("FAIL frame_lines pulses=%0d want=11", ls); end
        n_total++;
        if (fs_clk != 352) begin n_bad++; $display("FAIL frame_period clk=%0d want=352", fs_clk); end
        n_total++;
        if (vs_low != 32 || vs_first != 700) begin
            n_bad++; $display("FAIL vsync_window ticks=%0d first(vc*100+hc)=%0d want 32 700", vs_low, vs_first);
        end
        n_total++;
        if (vid != 48) begin n_bad++; $display("FAIL frame_video ticks=%0d want=48", vid); end
        n_total++;
        if (p_err != 0) begin n_bad++; $display("FAIL pulse_single extra=%0d want=0", p_err); end
        n_total++;
        if ({s_hc, s_vc} !== 20'd0 || {s_frame_start, s_line_start} !== 2'b11) begin
            n_bad++; $display("FAIL v_wrap hc=%0d vc=%0d fs=%b ls=%b want 0 0 1 1",
                              s_hc, s_vc, s_frame_start, s_line_start);
        end
    endtask

    task automatic test_clr_mid();
        restart();
        for (int k = 1; k <= 123; k++) step(1'b1);
        n_total++;
        if ({s_hc, s_vc} !== {10'd11, 10'd7} || {s_hsync, s_vsync, s_video_on} !== 3'b000) begin
            n_bad++; $display("FAIL pre_clr hc=%0d vc=%0d flags=%b want 11 7 000", s_hc, s_vc,
                              {s_hsync, s_vsync, s_video_on});
        end
        clr = 1'b1;
        step(1'b1);
        clr = 1'b0;
        n_total++;
        if ({s_hc, s_vc, s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start} !== {20'd0, 5'b11000}) begin
            n_bad++; $display("FAIL clr_small hc=%0d vc=%0d flags=%b want 0 0 11000", s_hc, s_vc,
                              {s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start});
        end
        n_total++;
        if ({hc, vc, hsync, vsync, video_on, line_start, frame_start} !== {20'd0, 5'b11000}) begin
            n_bad++; $display("FAIL clr_full hc=%0d vc=%0d flags=%b want 0 0 11000", hc, vc,
                              {hsync, vsync, video_on, line_start, frame_start});
        end
        step(1'b0);
        n_total++;
        if ({s_video_on, s_frame_start, s_line_start} !== 3'b000 || s_hc !== 10'd0) begin
            n_bad++; $display("FAIL clr_idle flags=%b hc=%0d want 000 0", {s_video_on, s_frame_start, s_line_start}, s_hc);
        end
        step(1'b1);
        n_total++;
        if ({s_frame_start, s_line_start, s_video_on} !== 3'b111 || s_hc !== 10'd0) begin
            n_bad++; $display("FAIL clr_restart flags=%b hc=%0d want 111 0", {s_frame_start, s_line_start, s_video_on}, s_hc);
        end
        step(1'b1);
        n_total++;
        if (s_hc !== 10'd1 || s_frame_start !== 1'b0) begin
            n_bad++; $display("FAIL clr_first_tick hc=%0d fs=%b want 1 0", s_hc, s_frame_start);
        end
    endtask

    task automatic test_enable_drop();
        for (int k = 0; k < 4; k++) step(1'b1);
        n_total++;
        if (hc !== 10'd5) begin n_bad++; $display("FAIL en_pre hc=%0d want=5", hc); end
        enable = 1'b0;
        step(1'b1);
        n_total++;
        if ({hc, vc} !== 20'd0 || {video_on, line_start, frame_start, hsync} !== 4'b0001) begin
            n_bad++; $display("FAIL en_drop hc=%0d vc=%0d flags=%b want 0 0 0001", hc, vc,
                              {video_on, line_start, frame_start, hsync});
        end
        step(1'b1);
        n_total++;
        if (hc !== 10'd0 || video_on !== 1'b0) begin
            n_bad++; $display("FAIL en_hold hc=%0d vo=%b want 0 0", hc, video_on);
        end
        enable = 1'b1;
        step(1'b0);
        n_total++;
        if (frame_start !== 1'b0 || video_on !== 1'b0) begin
            n_bad++; $display("FAIL en_wait fs=%b vo=%b want 0 0", frame_start, video_on);
        end
        step(1'b1);
        n_total++;
        if ({frame_start, line_start, video_on} !== 3'b111 || hc !== 10'd0) begin
            n_bad++; $display("FAIL en_restart flags=%b hc=%0d want 111 0", {frame_start, line_start, video_on}, hc);
        end
    endtask

    task automatic test_freeze();
        int frz_err = 0;
        for (int k = 1; k <= 660; k++) step(1'b1);
        n_total++;
        if ({hc, vc} !== {10'd660, 10'd0}) begin
            n_bad++; $display("FAIL frz_pre hc=%0d vc=%0d want 660 0", hc, vc);
        end
        for (int k = 0; k < 100; k++) begin
            step(1'b0);
            if ({hc, vc} !== {10'd660, 10'd0} ||
                {hsync, vsync, video_on, line_start, frame_start} !== 5'b01000) frz_err++;
        end
        n_total++;
        if (frz_err != 0) begin n_bad++; $display("FAIL freeze cycles_changed=%0d want=0", frz_err); end
        step(1'b1);
        n_total++;
        if (hc !== 10'd661) begin n_bad++; $display("FAIL frz_resume hc=%0d want=661", hc); end
    endtask

    task automatic test_full_rate();
        int s_err = 0, fs_early = 0;
        restart();
        for (int k = 1; k <= 800; k++) begin
            step(1'b1);
            if (k <= 176) begin
                if (s_hc !== 10'(k % 16) || s_vc !== 10'((k / 16) % 11)) s_err++;
                if (k < 176 && s_frame_start) fs_early++;
            end
            if (k == 176) begin
                n_total++;
                if ({s_frame_start, s_line_start} !== 2'b11 || {s_hc, s_vc} !== 20'd0) begin
                    n_bad++; $display("FAIL fast_vwrap fs=%b ls=%b hc=%0d vc=%0d want 1 1 0 0",
                                      s_frame_start, s_line_start, s_hc, s_vc);
                end
            end
            if (k == 799) begin
                n_total++;
                if ({hc, vc} !== {10'd799, 10'd0}) begin
                    n_bad++; $display("FAIL fast_hlast hc=%0d vc=%0d want 799 0", hc, vc);
                end
            end
        end
        n_total++;
        if ({hc, vc} !== {10'd0, 10'd1} || {line_start, frame_start} !== 2'b10) begin
            n_bad++; $display("FAIL fast_hwrap hc=%0d vc=%0d ls=%b fs=%b want 0 1 1 0", hc, vc, line_start, frame_start);
        end
        n_total++;
        if (s_err != 0 || fs_early != 0) begin
            n_bad++; $display("FAIL fast_sequence errors=%0d early_fs=%0d want 0 0", s_err, fs_early);
        end
    endtask

    initial begin
        clr    = 1'b1;
        pix_en = 1'b0;
        enable = 1'b0;
        test_reset();
        test_hline();
        test_frame();
        test_clr_mid();
        test_enable_drop();
        test_freeze();
        test_full_rate();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
